// File: rtl/data_gen_pkg.sv
// data_gen_pkg: pattern constants, next-value function and checker states shared by generator and checker
package data_gen_pkg;
  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_LFSR = 1'b1;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} chk_state_e;
  function automatic logic [7:0] next_value(input logic mode, input logic [7:0] x);
    return (mode == MODE_LFSR) ? ({x[6:0], x[7]} ^ {4'b0, x[7], 3'b0}) : x + 8'd1;
  endfunction
endpackage

// File: rtl/data_checker_if.sv
// data_checker_if: stream input and status output bundle of the data checker
interface data_checker_if #(parameter int CNT_W = 16);
  logic mode;
  logic data_valid;
  logic [7:0] data_in;
  logic clear;
  logic locked;
  logic err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  modport master (output mode, data_valid, data_in, clear,
                  input locked, err_pulse, err_count, sample_count);
  modport slave (input mode, data_valid, data_in, clear,
                 output locked, err_pulse, err_count, sample_count);
endinterface

// File: rtl/data_checker.sv
// data_checker: self-synchronising checker for counter/LFSR test streams with lock tracking and error counts
module data_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  data_checker_if.slave bus
);
  import data_gen_pkg::*;
  chk_state_e state_q, state_d;
  logic [7:0] exp_q, exp_d, match_q, match_d, miss_q, miss_d;
  logic mode_q, mode_d, err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, smp_q, smp_d;
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    match_d = match_q;
    miss_d = miss_q;
    mode_d = mode_q;
    err_d = 1'b0;
    if (bus.data_valid) begin
      mode_d = bus.mode;
      if (bus.mode != mode_q || state_q == SEARCH) begin
        // A mode change reseeds from any state without counting an error
        if (bus.mode == MODE_LFSR && bus.data_in == 8'h00) state_d = SEARCH;
        else begin
          exp_d = next_value(bus.mode, bus.data_in);
          match_d = 8'd0;
          state_d = VERIFY;
        end
      end else if (state_q == VERIFY) begin
        if (bus.data_in == exp_q) begin
          match_d = match_q + 8'd1;
          exp_d = next_value(bus.mode, bus.data_in);
          if (match_q + 8'd1 == 8'(LOCK_COUNT)) begin
            state_d = LOCKED;
            miss_d = 8'd0;
          end
        end else if (bus.mode == MODE_LFSR && bus.data_in == 8'h00) state_d = SEARCH;
        else begin
          exp_d = next_value(bus.mode, bus.data_in);
          match_d = 8'd0;
        end
      end else begin
        exp_d = next_value(bus.mode, exp_q);
        if (bus.data_in == exp_q) miss_d = 8'd0;
        else begin
          err_d = 1'b1;
          miss_d = miss_q + 8'd1;
          if (miss_q + 8'd1 == 8'(UNLOCK_COUNT)) state_d = SEARCH;
        end
      end
    end
    err_cnt_d = bus.clear ? '0 : (err_d && ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    smp_d = bus.clear ? '0 : (bus.data_valid && ~&smp_q) ? smp_q + CNT_W'(1) : smp_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      exp_q <= 8'h00;
      match_q <= 8'd0;
      miss_q <= 8'd0;
      mode_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      smp_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      match_q <= match_d;
      miss_q <= miss_d;
      mode_q <= mode_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      smp_q <= smp_d;
    end
  end
  assign bus.locked = state_q == LOCKED;
  assign bus.err_pulse = err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.sample_count = smp_q;
endmodule

// File: tb/tb_data_checker.sv
// tb_data_checker: directed-vector bench for data_checker
module tb_data_checker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  data_checker_if #(.CNT_W(16)) bus ();
  data_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic m, input logic [7:0] d, input logic clr = 1'b0);
    bus.mode = m;
    bus.data_in = d;
    bus.data_valid = 1'b1;
    bus.clear = clr;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.clear = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask
  initial begin
    logic [7:0] lf [10];
    lf = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h09, 8'h12};
    bus.mode = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in = 8'h00;
    bus.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_sample_count", bus.sample_count, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      send(1'b0, 8'(8'h10 + i));
      if (i == 3 || i == 4 || i == 16) chk($sformatf("seq_locked_%0d", i), bus.locked, i >= 4);
    end
    chk("seq_err_count", bus.err_count, 0);
    chk("seq_sample_count", bus.sample_count, 17);
    do_clear();
    chk("clear_idle_samples", bus.sample_count, 0);
    chk("clear_keeps_lock", bus.locked, 1);
    send(1'b0, 8'h21);
    chk("post_clear_samples", bus.sample_count, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_samples", bus.sample_count, 0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 8'hFD);
    send(1'b0, 8'hFE);
    send(1'b0, 8'hFF);
    send(1'b0, 8'h00);
    chk("wrap_not_yet", bus.locked, 0);
    send(1'b0, 8'h01);
    chk("wrap_locked", bus.locked, 1);
    send(1'b0, 8'h02);
    chk("wrap_still_locked", bus.locked, 1);
    chk("wrap_err_count", bus.err_count, 0);
    do_reset();
    send(1'b1, 8'h00);
    chk("illegal_seed_samples", bus.sample_count, 1);
    for (int i = 0; i < 10; i++) begin
      send(1'b1, lf[i]);
      if (i == 3 || i == 4) chk($sformatf("lfsr_locked_%0d", i), bus.locked, i >= 4);
    end
    send(1'b1, 8'h25);
    chk("bad_err_pulse", bus.err_pulse, 1);
    chk("bad_err_count", bus.err_count, 1);
    chk("bad_still_locked", bus.locked, 1);
    send(1'b1, 8'h48);
    chk("after_bad_pulse", bus.err_pulse, 0);
    chk("after_bad_count", bus.err_count, 1);
    send(1'b1, 8'h90);
    chk("after_bad_count2", bus.err_count, 1);
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 8'h00);
      if (i >= 6) chk($sformatf("zero_locked_%0d", i), bus.locked, i < 7);
    end
    chk("zero_err_count", bus.err_count, 8);
    send(1'b1, 8'h29);
    send(1'b1, 8'h52);
    send(1'b1, 8'hA4);
    send(1'b1, 8'h41);
    chk("relock_not_yet", bus.locked, 0);
    send(1'b1, 8'h82);
    chk("relock", bus.locked, 1);
    chk("relock_err_count", bus.err_count, 8);
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b0, 8'(8'h30 + i));
    chk("m0_locked", bus.locked, 1);
    send(1'b1, 8'h01);
    chk("switch_unlocked", bus.locked, 0);
    chk("switch_no_pulse", bus.err_pulse, 0);
    send(1'b1, 8'h02);
    send(1'b1, 8'h04);
    send(1'b1, 8'h08);
    chk("switch_not_yet", bus.locked, 0);
    send(1'b1, 8'h10);
    chk("switch_relock", bus.locked, 1);
    chk("switch_err_count", bus.err_count, 0);
    send(1'b1, 8'h77);
    chk("pre_clr_err", bus.err_count, 1);
    send(1'b1, 8'h77, 1'b1);
    chk("clr_err_count", bus.err_count, 0);
    chk("clr_err_pulse", bus.err_pulse, 1);
    chk("clr_samples", bus.sample_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_checker.md
# data_checker

Receive-side checker for the 8-bit test stream produced by the data generator. It self-synchronises to either the sequential-counter or the LFSR pattern and tracks the expected next value. It counts mismatches and reports lock status. It sits at the far end of the accelerator datapath under test, so a generator→DUT→checker loop gives pass/fail without a golden model.

## Interface
- LOCK_COUNT, 4: consecutive matches after the seed sample required to declare lock (≥1).
- UNLOCK_COUNT, 8: consecutive mismatches while locked that force resynchronisation (≥1).
- CNT_W, 16: width of the error and sample counters.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = sequential counter pattern, 1 = LFSR pattern; sampled only when data_valid=1.
- data_valid  in  1  data_in is a sample this cycle.
- data_in  in  8  received data.
- clear  in  1  synchronous clear of err_count and sample_count.
- locked  out  1  checker is tracking the stream.
- err_pulse  out  1  one-cycle pulse per mismatch counted while locked.
- err_count  out  CNT_W  saturating mismatch count.
- sample_count  out  CNT_W  saturating count of valid samples.

## Operation
- next(x), mode 0: x+1 mod 256 (0xFF→0x00).
- next(x), mode 1: {x[6:0],x[7]}, then bit3 ^= x[7]. Example chain: 0x01→0x02→…→0x80→0x09→0x12→0x24→0x48→0x90→0x29.
- Internal registers: state, expected[7:0], match_cnt, miss_cnt, mode_q (mode of the last valid sample).
- Cycles with data_valid=0 change nothing except clear.
- SEARCH (reset state), on valid:
  - mode 1 with data_in=0x00: illegal seed; stay in SEARCH.
  - Otherwise: expected←next(data_in), match_cnt←0, go to VERIFY.
- VERIFY, on valid:
  - data_in==expected: match_cnt++, expected←next(data_in). If this is match number LOCK_COUNT, go to LOCKED with miss_cnt←0.
  - Mismatch: reseed (expected←next(data_in), match_cnt←0) and stay in VERIFY. Exception: a mode-1 0x00 sample goes to SEARCH.
  - Errors are never counted in VERIFY.
- LOCKED, on valid:
  - Always: expected←next(expected). Free-running, so an isolated corrupted sample does not derail tracking.
  - Match: miss_cnt←0.
  - Mismatch: err_pulse, err_count++ (saturating), miss_cnt++.
  - When miss_cnt reaches UNLOCK_COUNT: go to SEARCH, locked falls.
- Mode change: a valid sample with mode≠mode_q is handled as a SEARCH seed using the new mode, from any state. No error is counted for that sample.
- sample_count increments on every valid sample and saturates at all-ones.
- err_count saturates at all-ones; further mismatches still pulse err_pulse.
- clear has priority over an increment in the same cycle: both counters go to 0 and that sample is not counted. The state machine and err_pulse are unaffected by clear.

## Timing
- All outputs are registered. The response to a sample at edge N is visible after edge N.
- Lock latency from SEARCH: 1 seed + LOCK_COUNT matching samples. locked rises the cycle after the last of these is sampled.
- err_pulse is high for exactly the cycle after the offending sample.
- Unlock: locked falls the cycle after the UNLOCK_COUNT-th consecutive mismatch.
- Reset values: locked=0, err_pulse=0, err_count=0, sample_count=0, state=SEARCH, expected=0, mode_q=0.
- Reset asserted mid-stream clears everything immediately (asynchronous). After release, reacquisition starts on the first valid sample.

## Structure
- Shared package data_gen_pkg:
  - MODE_SEQ/MODE_LFSR constants and LFSR_SEED=8'h01.
  - Function next_value(mode, x), to be adopted by the generator as well.
  - Checker state enum {SEARCH, VERIFY, LOCKED}.
- Single module; no sub-module needed. The pattern step is the package function.

## Test plan
- Mode 0, stream 0x10,0x11,…,0x20 (LOCK_COUNT=4) → locked rises after the 5th sample; err_count=0; sample_count=17.
- Mode 0 wrap, stream 0xFD,0xFE,0xFF,0x00,0x01,0x02 → locks with no errors.
- Mode 1, stream 0x01,0x02,…,0x80,0x09,0x12, then 0x25 sent in place of 0x24, then 0x48,0x90 → single err_pulse; err_count=1; locked stays 1; 0x48 matches.
- Locked, then 8 consecutive 0x00 samples in mode 1 → err_count=8; locked falls after the 8th. Resume the valid LFSR stream → relock after 5 samples.
- Locked in mode 0, switch mode to 1 mid-stream with a valid LFSR stream → locked=0 next cycle; relock after 5 samples; err_count unchanged.
- clear together with a mismatching valid sample → err_count=0 and err_pulse=1. Separately, reset_n low mid-lock → all outputs return to 0 without waiting for a clock edge.
